// File: rtl/mac_accumulator.sv
// mac_accumulator: sums up to TERMS unsigned products per burst and hands
// the registered sum, term count and sticky carry-out flag downstream.
module mac_accumulator #(
   parameter int N     = 4,
   parameter int ACC_W = 10,
   parameter int TERMS = 4,
   localparam int CW   = $clog2(TERMS + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [2*N-1:0]   prod,
   input  logic             prod_valid,
   output logic             prod_ready,
   input  logic             flush,
   input  logic             clear,
   output logic [ACC_W-1:0] acc_out,
   output logic [CW-1:0]    acc_cnt,
   output logic             acc_ovf,
   output logic             acc_valid,
   input  logic             acc_ready
);
   typedef enum logic {ACCUM, HOLD} state_t;
   state_t           state_q, state_d;
   logic [ACC_W-1:0] sum_q, sum_d, acc_out_q, acc_out_d;
   logic [CW-1:0]    cnt_q, cnt_d, acc_cnt_q, acc_cnt_d, cnt_inc;
   logic             ovf_q, ovf_d, acc_ovf_q, acc_ovf_d;
   logic [ACC_W:0]   add;
   logic             accept, done;

   assign prod_ready = state_q == ACCUM && !clear && !rst;
   assign accept     = prod_valid && prod_ready;
   assign add        = {1'b0, sum_q} + (ACC_W + 1)'(prod);
   assign cnt_inc    = cnt_q + CW'(accept);
   // The product accepted on the ending edge belongs to this burst.
   assign done       = state_q == ACCUM &&
                       ((accept && cnt_inc == CW'(TERMS)) || (flush && cnt_inc != '0));

   always_comb begin
      state_d   = state_q;
      sum_d     = sum_q;
      cnt_d     = cnt_q;
      ovf_d     = ovf_q;
      acc_out_d = acc_out_q;
      acc_cnt_d = acc_cnt_q;
      acc_ovf_d = acc_ovf_q;
      if (clear) begin
         state_d   = ACCUM;
         sum_d     = '0;
         cnt_d     = '0;
         ovf_d     = 1'b0;
         acc_out_d = '0;
         acc_cnt_d = '0;
         acc_ovf_d = 1'b0;
      end else if (state_q == HOLD) begin
         if (acc_ready) begin
            state_d = ACCUM;
            sum_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
         end
      end else begin
         if (accept) begin
            sum_d = add[ACC_W-1:0];
            cnt_d = cnt_inc;
            ovf_d = ovf_q | add[ACC_W];
         end
         if (done) begin
            state_d   = HOLD;
            acc_out_d = sum_d;
            acc_cnt_d = cnt_d;
            acc_ovf_d = ovf_d;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ACCUM;
         sum_q     <= '0;
         cnt_q     <= '0;
         ovf_q     <= 1'b0;
         acc_out_q <= '0;
         acc_cnt_q <= '0;
         acc_ovf_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         sum_q     <= sum_d;
         cnt_q     <= cnt_d;
         ovf_q     <= ovf_d;
         acc_out_q <= acc_out_d;
         acc_cnt_q <= acc_cnt_d;
         acc_ovf_q <= acc_ovf_d;
      end
   end

   assign acc_out   = acc_out_q;
   assign acc_cnt   = acc_cnt_q;
   assign acc_ovf   = acc_ovf_q;
   assign acc_valid = state_q == HOLD;
endmodule

// File: tb/tb_mac_accumulator.sv
// tb_mac_accumulator: drives a 10-bit and a 9-bit accumulator in lockstep and
// checks both against a queue-of-terms burst model.
module tb_mac_accumulator;
   logic       clk = 0, rst = 1;
   logic [7:0] prod = 0;
   logic       prod_valid = 0, flush = 0, clear = 0, acc_ready = 0;
   logic       prod_ready_a, acc_ovf_a, acc_valid_a;
   logic       prod_ready_b, acc_ovf_b, acc_valid_b;
   logic [9:0] acc_out_a;
   logic [8:0] acc_out_b;
   logic [2:0] acc_cnt_a, acc_cnt_b;

   int n_checks = 0, n_fail = 0;
   int q[$];
   bit m_hold = 0;
   int r_sum = 0, r_cnt = 0;
   logic rdy_obs_a, rdy_obs_b;
   bit rdy_exp;

   mac_accumulator #(.N(4), .ACC_W(10), .TERMS(4)) dut_a (
      .clk(clk), .rst(rst), .prod(prod), .prod_valid(prod_valid), .prod_ready(prod_ready_a),
      .flush(flush), .clear(clear), .acc_out(acc_out_a), .acc_cnt(acc_cnt_a),
      .acc_ovf(acc_ovf_a), .acc_valid(acc_valid_a), .acc_ready(acc_ready));

   mac_accumulator #(.N(4), .ACC_W(9), .TERMS(4)) dut_b (
      .clk(clk), .rst(rst), .prod(prod), .prod_valid(prod_valid), .prod_ready(prod_ready_b),
      .flush(flush), .clear(clear), .acc_out(acc_out_b), .acc_cnt(acc_cnt_b),
      .acc_ovf(acc_ovf_b), .acc_valid(acc_valid_b), .acc_ready(acc_ready));

   always #5 clk = ~clk;

   function automatic int qsum();
      int s = 0;
      foreach (q[i]) s += q[i];
      return s;
   endfunction

   // Drive one cycle's inputs, record ready mid-cycle, advance the burst model.
   task automatic cycle(input bit pv, input int p, input bit fl, input bit cl, input bit ar);
      bit acc;
      prod_valid = pv; prod = 8'(p); flush = fl; clear = cl; acc_ready = ar;
      #2;
      rdy_obs_a = prod_ready_a; rdy_obs_b = prod_ready_b;
      rdy_exp = !m_hold && !cl;
      acc = pv && rdy_exp;
      if (cl) begin
         q.delete(); m_hold = 0; r_sum = 0; r_cnt = 0;
      end else if (m_hold) begin
         if (ar) begin m_hold = 0; q.delete(); end
      end else begin
         if (acc) q.push_back(p);
         if ((acc && q.size() == 4) || (fl && q.size() > 0)) begin
            m_hold = 1; r_cnt = q.size(); r_sum = qsum();
         end
      end
      @(posedge clk); #1;
      prod_valid = 0; flush = 0; clear = 0; acc_ready = 0;
   endtask

   task automatic model_reset();
      q.delete(); m_hold = 0; r_sum = 0; r_cnt = 0;
   endtask

   task automatic test_reset();
      #3;
      n_checks++; if (prod_ready_a !== 0) begin n_fail++; $display("FAIL reset_ready got %0b want 0", prod_ready_a); end
      n_checks++; if (acc_valid_a !== 0 || acc_out_a !== 0 || acc_cnt_a !== 0 || acc_ovf_a !== 0) begin n_fail++; $display("FAIL reset_outs got v%0b o%0d c%0d f%0b want zeros", acc_valid_a, acc_out_a, acc_cnt_a, acc_ovf_a); end
      @(posedge clk); #2;
      rst = 0;
      @(posedge clk); #1;
      n_checks++; if (prod_ready_a !== 1) begin n_fail++; $display("FAIL post_reset_ready got %0b want 1", prod_ready_a); end
   endtask

   task automatic test_full_burst();
      for (int i = 0; i < 3; i++) cycle(1, 225, 0, 0, 0);
      n_checks++; if (acc_valid_a !== 0) begin n_fail++; $display("FAIL burst_early_valid got %0b want 0", acc_valid_a); end
      cycle(1, 225, 0, 0, 0);
      n_checks++; if (acc_valid_a !== 1 || acc_out_a !== 10'd900 || acc_cnt_a !== 3'd4 || acc_ovf_a !== 0) begin n_fail++; $display("FAIL burst_a got v%0b o%0d c%0d f%0b want v1 o900 c4 f0", acc_valid_a, acc_out_a, acc_cnt_a, acc_ovf_a); end
      n_checks++; if (acc_valid_b !== 1 || acc_out_b !== 9'd388 || acc_cnt_b !== 3'd4 || acc_ovf_b !== 1) begin n_fail++; $display("FAIL burst_b_wrap got v%0b o%0d c%0d f%0b want v1 o388 c4 f1", acc_valid_b, acc_out_b, acc_cnt_b, acc_ovf_b); end
      for (int i = 0; i < 2; i++) begin
         cycle(1, 5, 0, 0, 0);
         n_checks++; if (rdy_obs_a !== 0 || acc_out_a !== 10'd900) begin n_fail++; $display("FAIL hold_ready got r%0b o%0d want r0 o900", rdy_obs_a, acc_out_a); end
      end
      cycle(0, 0, 0, 0, 1);
      n_checks++; if (acc_valid_a !== 0) begin n_fail++; $display("FAIL handback_valid got %0b want 0", acc_valid_a); end
      for (int i = 0; i < 4; i++) cycle(1, 1, 0, 0, 0);
      n_checks++; if (acc_out_b !== 9'd4 || acc_ovf_b !== 0 || acc_out_a !== 10'd4) begin n_fail++; $display("FAIL ovf_cleared got b%0d f%0b a%0d want b4 f0 a4", acc_out_b, acc_ovf_b, acc_out_a); end
      cycle(0, 0, 0, 0, 1);
   endtask

   task automatic test_flush();
      cycle(1, 10, 0, 0, 0);
      cycle(1, 20, 1, 0, 0);
      n_checks++; if (acc_valid_a !== 1 || acc_out_a !== 10'd30 || acc_cnt_a !== 3'd2) begin n_fail++; $display("FAIL flush_result got v%0b o%0d c%0d want v1 o30 c2", acc_valid_a, acc_out_a, acc_cnt_a); end
      cycle(0, 0, 0, 0, 1);
      cycle(0, 0, 1, 0, 0);
      n_checks++; if (acc_valid_a !== 0 || acc_out_a !== 10'd30) begin n_fail++; $display("FAIL flush_empty got v%0b o%0d want v0 o30", acc_valid_a, acc_out_a); end
   endtask

   task automatic test_clear();
      cycle(1, 50, 0, 0, 0);
      cycle(1, 60, 0, 0, 0);
      cycle(1, 70, 0, 1, 0);
      n_checks++; if (rdy_obs_a !== 0) begin n_fail++; $display("FAIL clear_ready got %0b want 0", rdy_obs_a); end
      n_checks++; if (acc_valid_a !== 0 || acc_out_a !== 0 || acc_cnt_a !== 0) begin n_fail++; $display("FAIL clear_outs got v%0b o%0d c%0d want zeros", acc_valid_a, acc_out_a, acc_cnt_a); end
      for (int i = 0; i < 4; i++) cycle(1, 1, 0, 0, 0);
      n_checks++; if (acc_valid_a !== 1 || acc_out_a !== 10'd4 || acc_cnt_a !== 3'd4) begin n_fail++; $display("FAIL after_clear got v%0b o%0d c%0d want v1 o4 c4", acc_valid_a, acc_out_a, acc_cnt_a); end
      cycle(0, 0, 0, 0, 1);
   endtask

   task automatic test_backpressure();
      for (int i = 0; i < 4; i++) cycle(1, int'($urandom_range(0, 255)), 0, 0, 0);
      n_checks++; if (acc_valid_a !== 1 || acc_out_a !== 10'(r_sum) || acc_ovf_a !== (r_sum >= 1024)) begin n_fail++; $display("FAIL bp_result got v%0b o%0d want v1 o%0d", acc_valid_a, acc_out_a, r_sum % 1024); end
      for (int i = 0; i < 5; i++) begin
         cycle(1, 9, 0, 0, 0);
         n_checks++; if (rdy_obs_a !== 0 || acc_valid_a !== 1 || acc_out_a !== 10'(r_sum) || acc_cnt_a !== 3'd4) begin n_fail++; $display("FAIL bp_stable got r%0b v%0b o%0d c%0d want r0 v1 o%0d c4", rdy_obs_a, acc_valid_a, acc_out_a, acc_cnt_a, r_sum % 1024); end
      end
      cycle(1, 9, 0, 0, 1);
      n_checks++; if (rdy_obs_a !== 0 || acc_valid_a !== 0) begin n_fail++; $display("FAIL bp_bubble got r%0b v%0b want r0 v0", rdy_obs_a, acc_valid_a); end
      cycle(1, 7, 0, 0, 0);
      n_checks++; if (rdy_obs_a !== 1) begin n_fail++; $display("FAIL bp_first_accept got %0b want 1", rdy_obs_a); end
      cycle(0, 0, 1, 0, 0);
      n_checks++; if (acc_valid_a !== 1 || acc_out_a !== 10'd7 || acc_cnt_a !== 3'd1) begin n_fail++; $display("FAIL bp_next_burst got v%0b o%0d c%0d want v1 o7 c1", acc_valid_a, acc_out_a, acc_cnt_a); end
      cycle(0, 0, 0, 0, 1);
   endtask

   task automatic test_async_reset();
      cycle(1, 5, 0, 0, 0);
      cycle(1, 6, 0, 0, 0);
      #4 rst = 1;
      #1;
      n_checks++; if (acc_out_a !== 0 || acc_valid_a !== 0 || acc_cnt_a !== 0 || prod_ready_a !== 0) begin n_fail++; $display("FAIL async_reset got o%0d v%0b c%0d r%0b want zeros", acc_out_a, acc_valid_a, acc_cnt_a, prod_ready_a); end
      model_reset();
      #2 rst = 0;
      @(posedge clk); #1;
      for (int i = 0; i < 4; i++) cycle(1, 3, 0, 0, 0);
      n_checks++; if (acc_valid_a !== 1 || acc_out_a !== 10'd12 || acc_cnt_a !== 3'd4 || acc_ovf_a !== 0) begin n_fail++; $display("FAIL post_async got v%0b o%0d c%0d f%0b want v1 o12 c4 f0", acc_valid_a, acc_out_a, acc_cnt_a, acc_ovf_a); end
      cycle(0, 0, 0, 0, 1);
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         cycle($urandom_range(0, 3) != 0, int'($urandom_range(0, 255)), $urandom_range(0, 7) == 0,
               $urandom_range(0, 31) == 0, $urandom_range(0, 2) == 0);
         n_checks++; if (rdy_obs_a !== rdy_exp || rdy_obs_b !== rdy_exp) begin n_fail++; $display("FAIL rnd_ready @%0d got %0b/%0b want %0b", i, rdy_obs_a, rdy_obs_b, rdy_exp); end
         n_checks++; if (acc_valid_a !== m_hold || acc_valid_b !== m_hold) begin n_fail++; $display("FAIL rnd_valid @%0d got %0b/%0b want %0b", i, acc_valid_a, acc_valid_b, m_hold); end
         n_checks++; if (acc_out_a !== 10'(r_sum % 1024) || acc_cnt_a !== 3'(r_cnt) || acc_ovf_a !== (r_sum >= 1024)) begin n_fail++; $display("FAIL rnd_a @%0d got o%0d c%0d f%0b want o%0d c%0d f%0b", i, acc_out_a, acc_cnt_a, acc_ovf_a, r_sum % 1024, r_cnt, r_sum >= 1024); end
         n_checks++; if (acc_out_b !== 9'(r_sum % 512) || acc_cnt_b !== 3'(r_cnt) || acc_ovf_b !== (r_sum >= 512)) begin n_fail++; $display("FAIL rnd_b @%0d got o%0d c%0d f%0b want o%0d c%0d f%0b", i, acc_out_b, acc_cnt_b, acc_ovf_b, r_sum % 512, r_cnt, r_sum >= 512); end
      end
   endtask

   initial begin
      test_reset();
      test_full_burst();
      test_flush();
      test_clear();
      test_backpressure();
      test_async_reset();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
